// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and defaults for the 7-segment display arbiter.
package seg_display_arbiter_pkg;

  localparam int unsigned MAX_REQ          = 4;
  localparam int unsigned HEX_W            = 4 * MAX_REQ;
  localparam int unsigned DEF_HOLD_CYCLES  = 25_000_000;  // 1 s at 25 MHz
  localparam int unsigned DEF_BLANK_CYCLES = 2_500_000;   // 0.1 s at 25 MHz
  localparam int unsigned DEF_CNT_W        = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Pick nibble idx out of a packed vector of up to MAX_REQ hex digits.
  function automatic logic [3:0] nibble_sel(input logic [HEX_W-1:0] hex,
                                            input logic [1:0]       idx);
    return hex[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle between the sources and the arbiter.
interface seg_display_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   i_Req;
  logic [4*NUM_REQ-1:0] i_Hex;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [3:0]           o_Hex;
  logic                 o_Blank;
  logic                 o_Busy;

  modport master (
    output i_Req, i_Hex,
    input  o_Grant, o_Hex, o_Blank, o_Busy
  );

  modport slave (
    input  i_Req, i_Hex,
    output o_Grant, o_Hex, o_Blank, o_Busy
  );

endinterface

// File: rtl/seg_display_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr_i with wrap, or
// fixed lowest-index priority when SEG_ARB_FIXED_PRIO_EN is defined.
module seg_display_arbiter_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [IDX_W-1:0]   idx_c_o,
  output logic               valid_c_o
);

  logic [IDX_W-1:0] cand;

`ifdef SEG_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Lowest asserted index wins; pointer is ignored.
  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(i);
      if (!valid_c_o && req_i[cand]) begin
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
        valid_c_o     = 1'b1;
      end
    end
  end
`else
  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_i) + 32'(i)) % NUM_REQ);
      if (!valid_c_o && req_i[cand]) begin
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
        valid_c_o     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 7-segment digit between NUM_REQ sources with a minimum dwell
// per owner and a blank gap between owners. Define SEG_ARB_FIXED_PRIO_EN
// for fixed lowest-index priority instead of round-robin.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  seg_display_arbiter_if.slave        bus
);

  localparam int unsigned      IDX_W      = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [3:0]         hex_q;
  logic               blank_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [IDX_W-1:0]   ptr_d;
  logic [3:0]         win_hex;
  logic [3:0]         own_hex;
  logic               owner_req;
  logic               others_req;

  seg_display_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i     (bus.i_Req),
    .ptr_i     (ptr_q),
    .gnt_c_o   (arb_gnt),
    .idx_c_o   (arb_idx),
    .valid_c_o (arb_valid)
  );

  // Pointer value after the current owner gives up the display.
  always_comb begin
    ptr_d = '0;
`ifndef SEG_ARB_FIXED_PRIO_EN
    ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
`endif
  end

  // Nibble selection and owner/competitor request status.
  always_comb begin
    win_hex    = nibble_sel(HEX_W'(bus.i_Hex), 2'(arb_idx));
    own_hex    = nibble_sel(HEX_W'(bus.i_Hex), 2'(owner_q));
    owner_req  = bus.i_Req[owner_q];
    others_req = |(bus.i_Req & ~grant_q);
  end

  // Dwell FSM with registered display outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      hex_q   <= 4'h0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            owner_q <= arb_idx;
            grant_q <= arb_gnt;
            hex_q   <= win_hex;
            blank_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHOW: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!owner_req) begin
            // Source vanished: release early.
            ptr_q   <= ptr_d;
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            grant_q <= '0;
            blank_q <= 1'b1;
          end else if (cnt_q == HOLD_LAST) begin
            ptr_q <= ptr_d;
            if (others_req) begin
              state_q <= ST_BLANK;
              cnt_q   <= '0;
              grant_q <= '0;
              blank_q <= 1'b1;
            end else begin
              // Sole requester keeps the digit and refreshes its value.
              cnt_q <= '0;
              hex_q <= own_hex;
            end
          end
        end
        ST_BLANK: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            cnt_q <= '0;
            if (arb_valid) begin
              state_q <= ST_SHOW;
              owner_q <= arb_idx;
              grant_q <= arb_gnt;
              hex_q   <= win_hex;
              blank_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          grant_q <= '0;
          blank_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Grant = grant_q;
  assign bus.o_Hex   = hex_q;
  assign bus.o_Blank = blank_q;
  assign bus.o_Busy  = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (NUM_REQ=4, HOLD=8, BLANK=2).
module tb_seg_display_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam logic [9:0]  RST_VAL = 10'b0000_0000_10;
  localparam logic [9:0]  ALL_MSK = 10'b1111_1111_11;
  localparam logic [9:0]  BLK_MSK = 10'b1111_0000_11;

`ifdef SEG_ARB_FIXED_PRIO_EN
  localparam logic [3:0] T1_NEXT_G = 4'b0001;
  localparam logic [3:0] T1_NEXT_H = 4'h1;
`else
  localparam logic [3:0] T1_NEXT_G = 4'b0010;
  localparam logic [3:0] T1_NEXT_H = 4'h2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  seg_display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_CYCLES  (8),
    .BLANK_CYCLES (2),
    .CNT_W        (4)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  int         q_cyc[$];
  logic [9:0] q_exp[$];
  logic [9:0] q_msk[$];
  string      q_nm[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] outs();
    return {bus.o_Grant, bus.o_Hex, bus.o_Blank, bus.o_Busy};
  endfunction

  task automatic check(input string nm, input logic [9:0] act,
                       input logic [9:0] exp, input logic [9:0] msk);
    checks++;
    if ((act & msk) !== (exp & msk)) begin
      errors++;
      $display("FAIL %s @cyc %0d: got grant=%b hex=%h blank=%b busy=%b, want grant=%b hex=%h blank=%b busy=%b",
               nm, cyc, act[9:6], act[5:2], act[1], act[0],
               exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
      if (q_cyc[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not compared (now %0d)",
                 q_nm[0], q_cyc[0], cyc);
      end else begin
        check(q_nm[0], outs(), q_exp[0], q_msk[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_msk.pop_front());
      void'(q_nm.pop_front());
    end
  end

  // Drive inputs for one cycle and queue the outputs due after the next edge.
  task automatic step(input logic [3:0] req, input logic [15:0] hex,
                      input logic [3:0] eg, input logic [3:0] eh,
                      input logic eb, input logic ebusy,
                      input logic [9:0] msk, input string nm);
    bus.i_Req = req;
    bus.i_Hex = hex;
    q_cyc.push_back(cyc + 1);
    q_exp.push_back({eg, eh, eb, ebusy});
    q_msk.push_back(msk);
    q_nm.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic show_n(input logic [3:0] req, input logic [15:0] hex,
                        input logic [3:0] eg, input logic [3:0] eh,
                        input int n, input string nm);
    repeat (n) step(req, hex, eg, eh, 1'b0, 1'b1, ALL_MSK, nm);
  endtask

  task automatic blank_n(input logic [3:0] req, input logic [15:0] hex,
                         input int n, input string nm);
    repeat (n) step(req, hex, 4'b0000, 4'h0, 1'b1, 1'b1, BLK_MSK, nm);
  endtask

  // Assert reset between edges, check outputs before any clock, then release.
  task automatic do_reset(input logic [3:0] req, input logic [15:0] hex,
                          input string nm);
    #5;
    rst = 1'b1;
    #1;
    check({nm, "_async"}, outs(), RST_VAL, ALL_MSK);
    @(posedge clk);
    #1;
    step(req, hex, 4'b0000, 4'h0, 1'b1, 1'b0, ALL_MSK, {nm, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_Req = 4'b1111;
    bus.i_Hex = 16'h4321;
    rst       = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with all requests asserted, then release.
    step(4'b1111, 16'h4321, 4'b0000, 4'h0, 1'b1, 1'b0, ALL_MSK, "t1_reset_held");
    step(4'b1111, 16'h4321, 4'b0000, 4'h0, 1'b1, 1'b0, ALL_MSK, "t1_reset_held");
    rst = 1'b0;
    show_n(4'b1111, 16'h4321, 4'b0001, 4'h1, 8, "t1_show_r0");
    blank_n(4'b1111, 16'h4321, 2, "t1_blank");
    show_n(4'b1111, 16'h4321, T1_NEXT_G, T1_NEXT_H, 2, "t1_next_owner");

    // Sole requester: value held for the dwell, then re-latched with no blank.
    do_reset(4'b0100, 16'h0A00, "t2_rst");
    show_n(4'b0100, 16'h0A00, 4'b0100, 4'hA, 3, "t2_hold_a");
    show_n(4'b0100, 16'h0300, 4'b0100, 4'hA, 5, "t2_hold_a_input3");
    show_n(4'b0100, 16'h0300, 4'b0100, 4'h3, 4, "t2_relatch_3");

    do_reset(4'b1011, 16'h7654, "t3_rst_midshow");
`ifndef SEG_ARB_FIXED_PRIO_EN
    // Round-robin over {0,1,3}.
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 8, "t3_g0");
    blank_n(4'b1011, 16'h7654, 2, "t3_b0");
    show_n(4'b1011, 16'h7654, 4'b0010, 4'h5, 8, "t3_g1");
    blank_n(4'b1011, 16'h7654, 2, "t3_b1");
    show_n(4'b1011, 16'h7654, 4'b1000, 4'h7, 8, "t3_g3");
    blank_n(4'b1011, 16'h7654, 2, "t3_b3");
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 8, "t3_g0_again");
    blank_n(4'b1011, 16'h7654, 2, "t3_b0_again");

    // Owner 1 drops during show cycle 3; pointer moves to 2 so 3 beats 0.
    show_n(4'b1011, 16'h7654, 4'b0010, 4'h5, 4, "t4_g1");
    blank_n(4'b1001, 16'h7654, 2, "t4_early_blank");
    show_n(4'b1001, 16'h7654, 4'b1000, 4'h7, 3, "t4_g3");

    // Reset mid-show: arbitration restarts from requester 0.
    do_reset(4'b1011, 16'h7654, "t5_rst_midshow");
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 3, "t5_restart_r0");
`else
    // Fixed priority: requester 0 keeps winning while it requests.
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 8, "t6_g0");
    blank_n(4'b1011, 16'h7654, 2, "t6_b0");
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 8, "t6_g0_again");
    blank_n(4'b1011, 16'h7654, 2, "t6_b0_again");
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 3, "t6_g0_third");

    do_reset(4'b1011, 16'h7654, "t5_rst_midshow");
    show_n(4'b1011, 16'h7654, 4'b0001, 4'h4, 3, "t5_restart_r0");
`endif

    for (int i = 0; i < 4 && q_cyc.size() != 0; i++) @(negedge clk);
    #1;
    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left uncompared, want 0", q_cyc.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the board's single 7-segment digit, and its hex-to-segment decoder, between up to 4 requesters (counter units, switch monitors, status sources).
- Round-robin grant with a minimum hold (dwell) time, so each shown value stays readable, and a blank gap between owners.
- Output feeds the existing hex decoder; blank forces all segments off downstream.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- HOLD_CYCLES, 25000000, clocks a granted value is displayed (1 s at 25 MHz), >=2.
- BLANK_CYCLES, 2500000, clocks of blank gap between grants (0.1 s), >=1.
- CNT_W, 25, width of the shared dwell counter; must hold max(HOLD_CYCLES, BLANK_CYCLES)-1.

Ports:
- i_Clk, input, 1, system clock.
- i_Rst, input, 1, asynchronous active-high reset.
- i_Req, input, NUM_REQ, per-requester display request, level-sensitive.
- i_Hex, input, 4*NUM_REQ, packed hex nibbles; requester k uses bits [4k+3:4k].
- o_Grant, output, NUM_REQ, one-hot current owner; all-zero when none.
- o_Hex, output, 4, nibble to decoder (value latched at grant).
- o_Blank, output, 1, 1 = segments off.
- o_Busy, output, 1, 1 when in SHOW or BLANK.

Behaviour:
- Reset (async assert, sync release in logic terms) sets:
  - o_Grant=0, o_Hex=0, o_Blank=1, o_Busy=0.
  - state=IDLE, counter=0, rr pointer=0 (requester 0 has highest priority first).
- States: IDLE, SHOW, BLANK.
- IDLE:
  - o_Blank=1, no grant.
  - If any i_Req is set, pick the winner by round-robin starting at the pointer.
  - Next cycle: state=SHOW, o_Grant=onehot(winner), o_Hex=i_Hex[winner] sampled at that edge, o_Blank=0, counter=0.
  - Latency from request to display is 1 clock.
- SHOW:
  - Counter increments each clock. o_Hex is held (not live) for the whole dwell.
  - Owner drops i_Req before the hold expires: go to BLANK on the next edge. Early release is allowed; the hold is a maximum for a vanished source.
  - Counter==HOLD_CYCLES-1: pointer=winner+1 mod NUM_REQ. Then:
    - If any other requester is active, go to BLANK.
    - Else if the owner still requests, stay in SHOW, reset the counter, re-latch i_Hex[owner]. There is no blank flicker for a sole requester.
    - Else go to BLANK.
- BLANK:
  - o_Grant=0, o_Blank=1, counter increments.
  - At BLANK_CYCLES-1: arbitrate as in IDLE. If there is a winner, go to SHOW; else go to IDLE.
- Arbitration:
  - Combinational, over i_Req masked from the pointer with wrap.
  - The pointer advances only on hold expiry or early release (pointer=owner+1).
  - Requests arriving mid-SHOW wait; they are not preemptive.
- Simultaneous requests: the lowest index at or after the pointer wins.
- Reset mid-SHOW: outputs return to reset values immediately, without waiting for a clock.
- o_Busy = (state != IDLE).
- o_Grant is at most one-hot in all states.

Optional Feature:
- SEG_ARB_FIXED_PRIO_EN defined:
  - Arbitration is fixed priority, lowest index wins; the pointer is unused (tie-off).
  - A higher-priority request during SHOW still waits for hold expiry.
- Undefined: round-robin as above.

Decomposition:
- Shared package/header:
  - State encoding constants ST_IDLE=2'd0, ST_SHOW=2'd1, ST_BLANK=2'd2.
  - Default HOLD/BLANK cycle constants for 25 MHz.
- One natural sub-module, rr_arbiter: combinational (req, pointer) -> one-hot grant + valid, with the fixed-priority path under the macro.
- The dwell counter and FSM live in the top.

Test Plan (NUM_REQ=4, HOLD_CYCLES=8, BLANK_CYCLES=2):
1. Reset held with i_Req=4'b1111 -> o_Grant=0, o_Blank=1, o_Hex=0, o_Busy=0. Release: next edge o_Grant=0001, o_Hex=i_Hex[3:0].
2. i_Req=4'b0100 constant, i_Hex nibble2=4'hA then 4'h3 mid-hold:
   - o_Hex stays A for 8 clocks, then becomes 3 with no blank cycle.
   - o_Grant stays 0100 throughout.
3. i_Req=4'b1011 constant -> grants 0001, 0010, 1000, 0001 in sequence. Each shows 8 clocks, separated by exactly 2 blank clocks.
4. Owner 1 drops i_Req at SHOW cycle 3 -> BLANK next edge. Pointer=2, so the next winner among {0,3} is 3.
5. Async i_Rst pulse mid-SHOW (between clock edges) -> outputs at reset values immediately. After release, arbitration restarts from requester 0.
6. With SEG_ARB_FIXED_PRIO_EN and i_Req=4'b1011 -> grant sequence 0001, 0001, ...; requester 3 is never granted while 0 requests.
